sa_tile_scheduler: RTL and testbench

Sequences the 16x16 systolic array (SA_mat_manager + SA_wrapper) over a tiled matmul C(M x N) = X(M x K) * W(K x N), with every dimension given in tiles. For each output tile it issues one SA start per K-chunk, flags accumulator clear on the first chunk and hands the finished tile to write-back. It also guards each SA run with a watchdog. It sits between the MHA top-level controller (command source) and the SA datapath / output buffer.

---
 rtl/sa_tile_scheduler.sv | 205 ++++++++++++++++++++
 tb/tb_sa_tile_scheduler.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_tile_scheduler.sv
// sa_tile_scheduler
//   Walks a tiled matmul C(MxN) = X(MxK) * W(KxN) over the systolic array.
//   For every output tile (i,j) it fires one SA start per K-chunk (k inner),
//   marks the first chunk so the SA clears its accumulators, waits for each
//   SA run to finish under a watchdog, then offers the tile to write-back.
//   Loop order is i outer, j middle, k inner.
//
// Ports
//   I_CLK, I_SYNC_RST            clock, synchronous active-high reset
//   I_CMD_VLD / O_CMD_RDY        command handshake (ready only when idle)
//   I_M_TILES/I_K_TILES/I_N_TILES  matmul dimensions in tiles, sampled at accept
//   O_SA_START, O_ACC_CLR        one-cycle SA start, accumulator-clear qualifier
//   O_I_IDX/O_K_IDX/O_J_IDX      current tile indices
//   I_SA_DONE                    SA run complete pulse (honoured only in WAIT)
//   O_WB_VLD / I_WB_RDY          finished-tile write-back handshake
//   O_BUSY, O_DONE               activity level, one-cycle completion pulse
//   O_ERR, O_ERR_CODE            sticky error: 01 zero dimension, 10 watchdog
//
// Every output is a register or a decode of registered state; there is no
// combinational path from any input to any output.

module sa_tile_scheduler #(
    parameter int D_W    = 16,
    parameter int SA_R   = 16,
    parameter int SA_C   = 16,
    parameter int TILE_W = 8,
    parameter int WDOG_W = 12
) (
    input  logic              I_CLK,
    input  logic              I_SYNC_RST,
    input  logic              I_CMD_VLD,
    output logic              O_CMD_RDY,
    input  logic [TILE_W-1:0] I_M_TILES,
    input  logic [TILE_W-1:0] I_K_TILES,
    input  logic [TILE_W-1:0] I_N_TILES,
    output logic              O_SA_START,
    output logic              O_ACC_CLR,
    output logic [TILE_W-1:0] O_I_IDX,
    output logic [TILE_W-1:0] O_K_IDX,
    output logic [TILE_W-1:0] O_J_IDX,
    input  logic              I_SA_DONE,
    output logic              O_WB_VLD,
    input  logic              I_WB_RDY,
    output logic              O_BUSY,
    output logic              O_DONE,
    output logic              O_ERR,
    output logic [1:0]        O_ERR_CODE
);

    // Datapath geometry is informational only; a degenerate geometry simply
    // never accepts work.
    localparam bit CFG_OK = (D_W > 0) && (SA_R > 0) && (SA_C > 0);

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_ZDIM = 2'b01;
    localparam logic [1:0] ERR_WDOG = 2'b10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        WB    = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t              state, state_nxt;
    logic [TILE_W-1:0]   m_last, k_last, n_last;
    logic [TILE_W-1:0]   m_last_nxt, k_last_nxt, n_last_nxt;
    logic [TILE_W-1:0]   i_idx, k_idx, j_idx;
    logic [TILE_W-1:0]   i_idx_nxt, k_idx_nxt, j_idx_nxt;
    logic [WDOG_W-1:0]   wdog, wdog_nxt;
    logic                err, err_nxt;
    logic [1:0]          err_code, err_code_nxt;

    logic cmd_take;
    logic zero_dim;
    logic k_is_last, j_is_last, i_is_last;

    assign cmd_take  = I_CMD_VLD && CFG_OK;
    assign zero_dim  = (I_M_TILES == '0) || (I_K_TILES == '0) || (I_N_TILES == '0);
    // Compares against latched (dim-1) so the index counters never need to
    // reach 2^TILE_W.
    assign k_is_last = (k_idx == k_last);
    assign j_is_last = (j_idx == n_last);
    assign i_is_last = (i_idx == m_last);

    always_ff @(posedge I_CLK) begin
        if (I_SYNC_RST) begin
            state    <= IDLE;
            m_last   <= '0;
            k_last   <= '0;
            n_last   <= '0;
            i_idx    <= '0;
            k_idx    <= '0;
            j_idx    <= '0;
            wdog     <= '0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            state    <= state_nxt;
            m_last   <= m_last_nxt;
            k_last   <= k_last_nxt;
            n_last   <= n_last_nxt;
            i_idx    <= i_idx_nxt;
            k_idx    <= k_idx_nxt;
            j_idx    <= j_idx_nxt;
            wdog     <= wdog_nxt;
            err      <= err_nxt;
            err_code <= err_code_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        m_last_nxt   = m_last;
        k_last_nxt   = k_last;
        n_last_nxt   = n_last;
        i_idx_nxt    = i_idx;
        k_idx_nxt    = k_idx;
        j_idx_nxt    = j_idx;
        wdog_nxt     = wdog;
        err_nxt      = err;
        err_code_nxt = err_code;

        unique case (state)
            IDLE: begin
                if (cmd_take) begin
                    m_last_nxt   = I_M_TILES - 1'b1;
                    k_last_nxt   = I_K_TILES - 1'b1;
                    n_last_nxt   = I_N_TILES - 1'b1;
                    i_idx_nxt    = '0;
                    k_idx_nxt    = '0;
                    j_idx_nxt    = '0;
                    wdog_nxt     = '0;
                    if (zero_dim) begin
                        err_nxt      = 1'b1;
                        err_code_nxt = ERR_ZDIM;
                        state_nxt    = FIN;
                    end else begin
                        err_nxt      = 1'b0;
                        err_code_nxt = ERR_NONE;
                        state_nxt    = ISSUE;
                    end
                end
            end

            ISSUE: begin
                wdog_nxt  = '0;
                state_nxt = WAIT;
            end

            WAIT: begin
                if (I_SA_DONE) begin
                    if (k_is_last) begin
                        state_nxt = WB;
                    end else begin
                        k_idx_nxt = k_idx + 1'b1;
                        state_nxt = ISSUE;
                    end
                end else if (wdog == {WDOG_W{1'b1}}) begin
                    // Counter has sat at its maximum with no completion.
                    err_nxt      = 1'b1;
                    err_code_nxt = ERR_WDOG;
                    state_nxt    = FIN;
                end else begin
                    wdog_nxt = wdog + 1'b1;
                end
            end

            WB: begin
                if (I_WB_RDY) begin
                    k_idx_nxt = '0;
                    if (j_is_last) begin
                        j_idx_nxt = '0;
                        i_idx_nxt = i_idx + 1'b1;
                    end else begin
                        j_idx_nxt = j_idx + 1'b1;
                    end
                    state_nxt = (i_is_last && j_is_last) ? FIN : ISSUE;
                end
            end

            FIN: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign O_CMD_RDY  = (state == IDLE);
    assign O_SA_START = (state == ISSUE);
    assign O_ACC_CLR  = (state == ISSUE) && (k_idx == '0);
    assign O_WB_VLD   = (state == WB);
    assign O_BUSY     = (state != IDLE);
    assign O_DONE     = (state == FIN);
    assign O_I_IDX    = i_idx;
    assign O_K_IDX    = k_idx;
    assign O_J_IDX    = j_idx;
    assign O_ERR      = err;
    assign O_ERR_CODE = err_code;

endmodule

// File: tb/tb_sa_tile_scheduler.sv
// Directed bench for sa_tile_scheduler. Inputs are driven and outputs sampled
// on the falling clock edge. A second instance with a 4-bit watchdog shares
// all inputs and is only examined for the timeout scenario.

module tb_sa_tile_scheduler;

    logic       clk = 1'b0;
    logic       rst, cmd_vld, sa_done, wb_rdy;
    logic [7:0] m_in, k_in, n_in;

    logic       cmd_rdy, sa_start, acc_clr, wb_vld, busy, done, err;
    logic [7:0] i_idx, k_idx, j_idx;
    logic [1:0] err_code;

    logic       cmd_rdy_w, sa_start_w, acc_clr_w, wb_vld_w, busy_w, done_w, err_w;
    logic [7:0] i_idx_w, k_idx_w, j_idx_w;
    logic [1:0] err_code_w;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sa_tile_scheduler dut (
        .I_CLK(clk), .I_SYNC_RST(rst), .I_CMD_VLD(cmd_vld), .O_CMD_RDY(cmd_rdy),
        .I_M_TILES(m_in), .I_K_TILES(k_in), .I_N_TILES(n_in),
        .O_SA_START(sa_start), .O_ACC_CLR(acc_clr),
        .O_I_IDX(i_idx), .O_K_IDX(k_idx), .O_J_IDX(j_idx),
        .I_SA_DONE(sa_done), .O_WB_VLD(wb_vld), .I_WB_RDY(wb_rdy),
        .O_BUSY(busy), .O_DONE(done), .O_ERR(err), .O_ERR_CODE(err_code)
    );

    sa_tile_scheduler #(.WDOG_W(4)) dut_w (
        .I_CLK(clk), .I_SYNC_RST(rst), .I_CMD_VLD(cmd_vld), .O_CMD_RDY(cmd_rdy_w),
        .I_M_TILES(m_in), .I_K_TILES(k_in), .I_N_TILES(n_in),
        .O_SA_START(sa_start_w), .O_ACC_CLR(acc_clr_w),
        .O_I_IDX(i_idx_w), .O_K_IDX(k_idx_w), .O_J_IDX(j_idx_w),
        .I_SA_DONE(sa_done), .O_WB_VLD(wb_vld_w), .I_WB_RDY(wb_rdy),
        .O_BUSY(busy_w), .O_DONE(done_w), .O_ERR(err_w), .O_ERR_CODE(err_code_w)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Outputs packed as {rdy,start,clr,wb,done,busy,err,code,i,k,j}
    function automatic logic [32:0] outs();
        return {cmd_rdy, sa_start, acc_clr, wb_vld, done, busy, err, err_code, i_idx, k_idx, j_idx};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cmd_vld = 1'b0; sa_done = 1'b0; wb_rdy = 1'b0;
        m_in = '0; k_in = '0; n_in = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- table-driven vectors ----------------
    typedef struct {
        logic       vld;
        logic [7:0] m, k, n;
        logic       sdone, rdy;
        logic [32:0] exp;   // expected outputs sampled before these inputs apply
    } vec_t;

    function automatic vec_t mk(input logic vld, input logic [7:0] m, k, n,
                                input logic sdone, rdy, input logic [32:0] exp);
        vec_t v;
        v.vld = vld; v.m = m; v.k = k; v.n = n; v.sdone = sdone; v.rdy = rdy; v.exp = exp;
        return v;
    endfunction

    // Field helpers for expected words
    function automatic logic [32:0] ex(input logic rdy, st, clr, wb, dn, bsy, er,
                                       input logic [1:0] code, input logic [7:0] i, k, j);
        return {rdy, st, clr, wb, dn, bsy, er, code, i, k, j};
    endfunction

    // ---------------- multi-cycle runner ----------------
    logic [24:0] st_q[$];    // {clr,i,k,j} per SA start
    int          stc_q[$];   // cycle of each start
    logic [15:0] acc_q[$];   // {i,j} per accepted write-back
    int          done_cnt, wb_cycles, first_acc_cyc;
    bit          unstable;

    task automatic run_cmd(input int m, k, n, dly, input bit tied, input int hold);
        int dcnt = 0;
        int hold_left = hold;
        int cyc = 0;
        bit seen_done = 0;
        bit prev_wb = 0;
        logic [15:0] prev_ij = '0;
        st_q.delete(); stc_q.delete(); acc_q.delete();
        done_cnt = 0; wb_cycles = 0; first_acc_cyc = -1; unstable = 0;
        @(negedge clk);
        cmd_vld = 1'b1; m_in = m[7:0]; k_in = k[7:0]; n_in = n[7:0];
        while (!seen_done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            cmd_vld = 1'b0; sa_done = 1'b0; wb_rdy = tied;
            if (sa_start) begin
                st_q.push_back({acc_clr, i_idx, k_idx, j_idx});
                stc_q.push_back(cyc);
                dcnt = dly;
            end else if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0) sa_done = 1'b1;
            end
            if (wb_vld) begin
                wb_cycles++;
                if (prev_wb && {i_idx, j_idx} != prev_ij) unstable = 1;
                if (tied || hold_left == 0) begin
                    wb_rdy = 1'b1;
                    acc_q.push_back({i_idx, j_idx});
                    if (first_acc_cyc < 0) first_acc_cyc = cyc;
                end else begin
                    hold_left--;
                end
            end
            prev_wb = wb_vld;
            prev_ij = {i_idx, j_idx};
            if (done) begin
                done_cnt++;
                seen_done = 1;
            end
        end
        if (!seen_done) chk("run_timeout", 64'd0, 64'd1);
        @(negedge clk);
        sa_done = 1'b0; wb_rdy = 1'b0;
        chk("post_rdy", {63'd0, cmd_rdy}, 64'd1);
        chk("post_busy_done", {62'd0, busy, done}, 64'd0);
    endtask

    vec_t vecs[$];

    initial begin
        rst = 1'b1; cmd_vld = 1'b0; sa_done = 1'b0; wb_rdy = 1'b0;
        m_in = '0; k_in = '0; n_in = '0;

        // ---- reset state ----
        do_reset();
        chk("reset_outs", {31'd0, outs()}, {31'd0, ex(1,0,0,0,0,0,0,2'b00,0,0,0)});
        chk("reset_outs_w", {63'd0, cmd_rdy_w & ~busy_w & ~err_w}, 64'd1);

        // ---- zero dimensions, error clear, ignored done in ISSUE ----
        vecs.push_back(mk(1,1,0,1,0,0, ex(1,0,0,0,0,0,0,2'b00,0,0,0)));
        vecs.push_back(mk(0,0,0,0,0,0, ex(0,0,0,0,1,1,1,2'b01,0,0,0)));
        vecs.push_back(mk(1,0,1,1,0,0, ex(1,0,0,0,0,0,1,2'b01,0,0,0)));
        vecs.push_back(mk(0,0,0,0,0,0, ex(0,0,0,0,1,1,1,2'b01,0,0,0)));
        vecs.push_back(mk(1,1,1,0,0,0, ex(1,0,0,0,0,0,1,2'b01,0,0,0)));
        vecs.push_back(mk(0,0,0,0,0,0, ex(0,0,0,0,1,1,1,2'b01,0,0,0)));
        vecs.push_back(mk(1,1,1,1,0,0, ex(1,0,0,0,0,0,1,2'b01,0,0,0)));
        vecs.push_back(mk(0,0,0,0,1,0, ex(0,1,1,0,0,1,0,2'b00,0,0,0)));
        vecs.push_back(mk(0,0,0,0,1,0, ex(0,0,0,0,0,1,0,2'b00,0,0,0)));
        vecs.push_back(mk(0,0,0,0,0,1, ex(0,0,0,1,0,1,0,2'b00,0,0,0)));
        vecs.push_back(mk(0,0,0,0,0,0, ex(0,0,0,0,1,1,0,2'b00,1,0,0)));
        vecs.push_back(mk(0,0,0,0,0,0, ex(1,0,0,0,0,0,0,2'b00,1,0,0)));
        for (int v = 0; v < vecs.size(); v++) begin
            @(negedge clk);
            chk($sformatf("vec%0d", v), {31'd0, outs()}, {31'd0, vecs[v].exp});
            cmd_vld = vecs[v].vld; m_in = vecs[v].m; k_in = vecs[v].k; n_in = vecs[v].n;
            sa_done = vecs[v].sdone; wb_rdy = vecs[v].rdy;
        end

        // ---- 1x1x1, done 20 cycles after start ----
        do_reset();
        run_cmd(1, 1, 1, 20, 1'b0, 0);
        chk("t1_nstart", st_q.size(), 1);
        if (st_q.size() == 1) chk("t1_start", st_q[0], {1'b1, 24'h000000});
        if (stc_q.size() >= 1) chk("t1_first_lat", stc_q[0], 1);
        chk("t1_nwb", acc_q.size(), 1);
        if (acc_q.size() == 1) chk("t1_wb", acc_q[0], 16'h0000);
        chk("t1_done", done_cnt, 1);
        chk("t1_err", {62'd0, err, 1'b0}, 64'd0);

        // ---- 2x3x2, done 5 cycles after start, WB_RDY tied ----
        do_reset();
        run_cmd(2, 3, 2, 5, 1'b1, 0);
        chk("t2_nstart", st_q.size(), 12);
        begin
            int idx = 0;
            int nclr = 0;
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 2; j++)
                    for (int k = 0; k < 3; k++) begin
                        if (idx < st_q.size()) begin
                            chk($sformatf("t2_start%0d", idx), st_q[idx],
                                {(k == 0), i[7:0], k[7:0], j[7:0]});
                            nclr += st_q[idx][24];
                        end
                        idx++;
                    end
            chk("t2_nclr", nclr, 4);
        end
        if (stc_q.size() >= 2) chk("t2_gap", stc_q[1] - stc_q[0], 6);
        chk("t2_nwb", acc_q.size(), 4);
        if (acc_q.size() == 4) chk("t2_wb_order", {acc_q[0], acc_q[1], acc_q[2], acc_q[3]},
                                   64'h0000_0001_0100_0101);
        chk("t2_done", done_cnt, 1);

        // ---- 1x1x2, first tile write-back held off 6 cycles ----
        do_reset();
        run_cmd(1, 1, 2, 3, 1'b0, 6);
        chk("t3_wb_cycles", wb_cycles, 8);
        chk("t3_stable", {63'd0, unstable}, 64'd0);
        chk("t3_nstart", st_q.size(), 2);
        if (st_q.size() == 2) begin
            chk("t3_start2", st_q[1], {1'b1, 8'd0, 8'd0, 8'd1});
            chk("t3_start2_after_acc", stc_q[1], first_acc_cyc + 1);
        end
        chk("t3_wb_order", {acc_q.size() == 2 ? {acc_q[0], acc_q[1]} : 32'hffff_ffff}, 32'h0000_0001);

        // ---- watchdog timeout on the 4-bit instance ----
        do_reset();
        begin
            int wcnt = 0;
            int cyc = 0;
            int dn = 0;
            @(negedge clk);
            cmd_vld = 1'b1; m_in = 1; k_in = 1; n_in = 1;
            while (dn == 0 && cyc < 200) begin
                @(negedge clk);
                cyc++;
                cmd_vld = 1'b0;
                if (busy_w && !sa_start_w && !wb_vld_w && !done_w) wcnt++;
                if (done_w) begin
                    dn = 1;
                    chk("t5_err", {61'd0, err_w, err_code_w}, {61'd0, 1'b1, 2'b10});
                end
            end
            chk("t5_done_seen", dn, 1);
            // Counter reads 0..15 across the wait; the cycle it reads 15 is the last.
            chk("t5_wait_cycles", wcnt, 16);
            @(negedge clk);
            chk("t5_after", {61'd0, cmd_rdy_w, busy_w, done_w}, {61'd0, 3'b100});
            chk("t5_err_sticky", {62'd0, err_w, err_code_w == 2'b10}, 64'd3);
        end

        // ---- busy-time inputs ignored, reset aborts mid-run ----
        do_reset();
        begin
            int cyc = 0;
            int bad = 0;
            @(negedge clk);
            cmd_vld = 1'b1; m_in = 2; k_in = 2; n_in = 2;
            @(negedge clk);
            cmd_vld = 1'b0;
            while (!sa_start && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            chk("t6_start", {63'd0, sa_start}, 64'd1);
            sa_done = 1'b1;                       // lands while in ISSUE
            @(negedge clk);
            sa_done = 1'b0;
            chk("t6_wait_k", {31'd0, outs()}, {31'd0, ex(0,0,0,0,0,1,0,2'b00,0,0,0)});
            cmd_vld = 1'b1; m_in = 1; k_in = 1; n_in = 1;
            @(negedge clk);
            cmd_vld = 1'b0;
            chk("t6_cmd_ignored", {31'd0, outs()}, {31'd0, ex(0,0,0,0,0,1,0,2'b00,0,0,0)});
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk("t6_reset_outs", {31'd0, outs()}, {31'd0, ex(1,0,0,0,0,0,0,2'b00,0,0,0)});
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                if (done || sa_start || wb_vld || busy) bad++;
            end
            chk("t6_quiet", bad, 0);
        end
        run_cmd(1, 1, 1, 3, 1'b1, 0);
        chk("t6_fresh_nstart", st_q.size(), 1);
        chk("t6_fresh_nwb", acc_q.size(), 1);
        chk("t6_fresh_done", done_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
